// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle processor control path: state
// encodings, opcode constants, ALU operation classes and the datapath mux
// selects. The ALU control block imports this package for the ALUOp codes.
package multicycle_ctrl_fsm_pkg;

  // Fixed encodings: software and debug tools read these through the state port.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  // Opcodes, taken from IR[31:26].
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALU operation class handed to the ALU control block.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select: constant 4, sign-extended immediate, shifted immediate.
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PC source select: ALU result, ALUOut register, jump target.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All datapath controls as one bundle so a single '0 clears every one.
  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_retire_counter.sv
// Retired-instruction counter: 32-bit, increments by one per cycle with en
// high, wraps from all-ones to zero.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears count
//   en    - increment this cycle
//   count - current count
module retire_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its inputs, regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for a multicycle MIPS-style datapath. One state register plus
// Mealy output decode from (state, opcode, mem_ready). Memory-touching states
// hold until mem_ready. Undefined opcodes park the FSM in TRAP until reset.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   opcode[5:0]            - IR[31:26]
//   mem_ready              - memory access completes this cycle
//   PCWriteCond .. ALUSrcA - single-bit datapath controls
//   ALUSrcB, ALUOp,
//   PCSource [1:0]         - mux selects and ALU operation class
//   state[3:0]             - current state, for debug
//   illegal_op             - sticky undefined-opcode flag
//   instr_retired[31:0]    - completed-instruction count
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        PCWriteCond,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [31:0] instr_retired
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    ctrl    = '0;
    retire  = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC load only in the cycle the instruction word arrives.
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WRITE: begin
        // Write strobe stays up for the whole access, not just the last cycle.
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        retire             = 1'b1;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        // Unused encodings 13..15 recover to FETCH.
        state_d = S_FETCH;
      end
    endcase

    // Controls are gated by rst_n directly so they fall the instant reset
    // asserts, without waiting for the state register to clear.
    if (!rst_n) begin
      ctrl   = '0;
      retire = 1'b0;
    end
  end

  retire_counter u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire),
    .count (instr_retired)
  );

  assign PCWriteCond = ctrl.pc_write_cond;
  assign PCWrite     = ctrl.pc_write;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;

  assign state       = state_q;
  // TRAP is terminal, so the flag is sticky until reset.
  assign illegal_op  = rst_n && (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. The reference model describes
// each instruction as the list of states it walks through, with a per-state
// table of expected controls, and steps along that list every clock.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_retired;
  logic [15:0] obs_ctrl;

  multicycle_ctrl_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .PCWriteCond   (PCWriteCond),
    .PCWrite       (PCWrite),
    .IorD          (IorD),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemtoReg      (MemtoReg),
    .IRWrite       (IRWrite),
    .RegDst        (RegDst),
    .RegWrite      (RegWrite),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .PCSource      (PCSource),
    .state         (state),
    .illegal_op    (illegal_op),
    .instr_retired (instr_retired)
  );

  assign obs_ctrl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          path[$];   // states the current instruction visits, in order
  int          idx;       // position in path
  logic [31:0] exp_ret;
  bit          done;
  int          n_stall;

  // Cycles per instruction with memory always ready.
  function automatic int lat(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_SW: return 4;
      OP_BEQ, OP_J:         return 3;
      OP_LW:                return 5;
      default:              return 0;
    endcase
  endfunction

  // Expected control vector for a state, in obs_ctrl bit order.
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
    logic pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, srca;
    logic [1:0] srcb, aop, pcs;
    {pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, srca} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcwc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, srca, srcb, aop, pcs};
  endfunction

  task automatic start(input logic [5:0] op);
    opcode = op;
    idx    = 0;
    done   = 0;
    case (op)
      OP_R:      path = '{0, 1, 6, 7};
      OP_ADDI:   path = '{0, 1, 10, 11};
      OP_BEQ:    path = '{0, 1, 8};
      OP_J:      path = '{0, 1, 9};
      OP_SW:     path = '{0, 1, 2, 5};
      OP_LW:     path = '{0, 1, 2, 3, 4};
      default:   path = '{0, 1, 12};
    endcase
  endtask

  // One clock: drive mem_ready, check outputs, advance the model at the edge.
  // Entered and left at the falling edge.
  task automatic cycle(input logic mr);
    int st;
    st = path[idx];
    mem_ready = mr;
    #1;
    check("state",      32'(state),      32'(st));
    check("ctrl",       32'(obs_ctrl),   32'(exp_ctrl(st, mr)));
    check("illegal_op", 32'(illegal_op), 32'(st == 12));
    check("retired",    instr_retired,   exp_ret);
    @(posedge clk);
    if (st != 12) begin
      if ((st == 0 || st == 3 || st == 5) && !mr) begin
        n_stall++;
      end else begin
        idx++;
        if (idx == path.size()) begin
          idx = 0;
          exp_ret++;
          done = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  // Run one instruction to completion. rnd: random mem_ready; otherwise
  // mem_ready is held low for stall_n cycles while in stall_st.
  task automatic run_op(input logic [5:0] op, input bit rnd, input int stall_st, input int stall_n);
    int   cyc;
    int   left;
    logic mr;
    start(op);
    left    = stall_n;
    n_stall = 0;
    cyc     = 0;
    while (!done && cyc < 100) begin
      if (rnd) mr = ($urandom_range(99) < 65);
      else if (path[idx] == stall_st && left > 0) begin mr = 1'b0; left--; end
      else mr = 1'b1;
      cycle(mr);
      cyc++;
    end
    check("op_done", 32'(done), 32'd1);
    check("op_cycles", 32'(cyc), 32'(lat(op) + n_stall));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_state",   32'(state),      32'd0);
    check("rst_ctrl",    32'(obs_ctrl),   32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_retired", instr_retired,   32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    idx     = 0;
    exp_ret = '0;
    path    = '{0};
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    rst_n     = 1'b1;
    opcode    = OP_R;
    mem_ready = 1'b0;
    exp_ret   = '0;
    #2;
    do_reset();

    // R-type with memory always ready, straight out of reset.
    run_op(OP_R, 0, -1, 0);
    check("r_retired", instr_retired, 32'd1);

    // LW stalled two cycles in MEM_READ.
    run_op(OP_LW, 0, 3, 2);

    // Instruction fetch stalled three cycles.
    run_op(OP_R, 0, 0, 3);

    // Random instruction mix with random memory latency.
    for (int i = 0; i < 150; i++) begin
      run_op(ops[$urandom_range(5)], 1, -1, 0);
    end

    // Retire counter wrap.
    force dut.u_retire_counter.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_retire_counter.count;
    exp_ret = 32'hFFFF_FFFF;
    check("wrap_pre", instr_retired, 32'hFFFF_FFFF);
    run_op(OP_J, 0, -1, 0);
    check("wrap_post", instr_retired, 32'd0);

    // Reset asserted in the middle of a store.
    start(OP_SW);
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    mem_ready = 1'b0;
    #1;
    check("sw_state",    32'(state),    32'd5);
    check("sw_memwrite", 32'(MemWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    check("abort_state",    32'(state),    32'd0);
    check("abort_ctrl",     32'(obs_ctrl), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ret = '0;

    // First instruction after reset release.
    run_op(OP_ADDI, 0, -1, 0);

    // Undefined opcode traps and stays trapped regardless of mem_ready.
    start(OP_BAD);
    cycle(1'b1);
    cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'($urandom_range(1)));
    check("trap_illegal", 32'(illegal_op), 32'd1);
    do_reset();
    run_op(OP_BEQ, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
